msrv32_wb_arbiter: RTL and testbench
====================================

# msrv32_wb_arbiter

The writeback arbiter is the write-side master of the integer register file. It merges results from the single-cycle execute path (port A) and the long-latency load/multi-cycle path (port B) into the register file's single write port (`rd_addr`, `wr_en`, `rd`). Port B results are buffered in a small FIFO. The block also keeps a busy scoreboard of destination registers with outstanding long-latency ops, so decode can stall on RAW hazards.

## Interface
Parameters:
- `B_DEPTH`, default 2: port B FIFO depth, power of two, ≥2.
- `STARVE_LIMIT`, default 4: number of consecutive A-wins with B pending before B is forced through, range 1–15.

Ports:
- `clk_in` input 1: clock, all state updates on rising edge.
- `reset_in` input 1: reset is synchronous and active-low.
- `a_valid_in` input 1: port A result valid.
- `a_ready_out` output 1: port A accepted this cycle when high with `a_valid_in`.
- `a_rd_addr_in` input 5: port A destination register.
- `a_data_in` input 32: port A result.
- `b_valid_in` input 1: port B result valid.
- `b_ready_out` output 1: port B FIFO can accept.
- `b_rd_addr_in` input 5: port B destination register.
- `b_data_in` input 32: port B result.
- `issue_valid_in` input 1: a long-latency op is issued this cycle.
- `issue_rd_addr_in` input 5: destination of the issued op.
- `rs_1_addr_in` input 5: decode source 1 address.
- `rs_2_addr_in` input 5: decode source 2 address.
- `hazard_out` output 1: combinational; a source register is busy.
- `busy_out` output 32: scoreboard, one bit per register; bit 0 is always 0.
- `wr_en_out` output 1: register file write enable.
- `rd_addr_out` output 5: register file write address.
- `rd_out` output 32: register file write data.

## Operation
- **Reset** (`reset_in`=0 at an edge):
  - `wr_en_out`=0, `rd_addr_out`=0, `rd_out`=0.
  - `busy_out`=0, FIFO empty, starve counter=0.
  - While `reset_in`=0, `a_ready_out`=0 and `b_ready_out`=0.
  - A reset mid-operation discards all FIFO contents and pending busy bits.
- **B push:** `b_ready_out` = !full. A push occurs on `b_valid_in && b_ready_out`. A full FIFO does not accept, even if it pops in the same cycle.
- **Select, each cycle, in priority order:**
  1. Force state: starve counter == `STARVE_LIMIT` and FIFO non-empty. Then `a_ready_out`=0, the FIFO head pops, and the counter clears.
  2. Otherwise, if `a_valid_in`, A is accepted (`a_ready_out`=1). If the FIFO is non-empty, the counter increments (saturating).
  3. Otherwise, if the FIFO is non-empty, the head pops and the counter clears.
  4. Otherwise, no write occurs and the counter clears.
- In all non-force cycles, `a_ready_out`=1.
- The counter clears whenever the FIFO is empty.
- **Output register:** the selected entry is registered into `rd_addr_out`/`rd_out`. `wr_en_out`=1 only if the selected destination is nonzero. x0 results are consumed but never written.
- **Scoreboard:**
  - Set: `busy[issue_rd_addr_in]` is set on `issue_valid_in` when the address is nonzero.
  - Clear: `busy[b_rd_addr]` is cleared when a B entry pops.
  - Same register set and cleared in one cycle: set wins.
  - Port A writes never touch busy bits.
- **Hazard:** `hazard_out` = (`busy[rs_1]` && rs_1≠0) || (`busy[rs_2]` && rs_2≠0). It reflects registered busy state only; a same-cycle issue is not seen.
- **FIFO pointers:** log2(`B_DEPTH`)+1 bits wide, wrap naturally; full and empty are decided by the MSB compare.

## Timing
- **A latency:** accepted at edge N; `wr_en_out`/`rd_addr_out`/`rd_out` are valid during cycle N→N+1; the register file commits at edge N+1.
- **B latency:** pushed at edge N; earliest pop at edge N+1 (no FIFO bypass); earliest commit at edge N+2.
- **Busy clear timing:** a busy bit clears at the pop edge, one cycle before the register file commit. The register file's write-forwarding covers the gap.
- **Output duration:** `wr_en_out` is high for exactly one cycle per written result. Back-to-back writes are allowed every cycle.
- **Port A stall:** `a_ready_out` drops for exactly one cycle per force event. The producer must hold A data stable until it is accepted.

## Test plan
- **Reset:** hold `reset_in`=0 for 2 cycles with all valids high, then release. Required: all outputs 0 during reset; `b_ready_out`=1 and `a_ready_out`=1 in the first cycle after release.
- **A only:** A writes x5=0x1234 at edge 1. Required: `wr_en_out`=1, `rd_addr_out`=5, `rd_out`=0x1234 in the cycle after edge 1. Then A writes x0=0xFFFF: `wr_en_out`=0.
- **B buffering:** `issue_valid_in` with rd=7; `busy_out[7]`=1 and `hazard_out`=1 with `rs_1_addr_in`=7. Then push B x7=0xA5A5 with no A traffic. Required: pop one cycle after the push, `busy_out[7]` clears at the pop edge, write x7=0xA5A5 one cycle later.
- **Full and back-pressure:** push 2 B entries (x1, x2) while A stays valid. Required: `b_ready_out`=0 once full; a third push is held.
- **Starvation:** with B entries pending and A valid continuously, A wins 4 cycles. Then `a_ready_out`=0 for one cycle and B x1 is written, followed by 4 more A wins and a forced x2 write.
- **Simultaneous set/clear:** issue rd=9 in the same cycle a B x9 entry pops. Required: `busy_out[9]` stays 1 and the x9 write still occurs.

Source files
------------

// File: rtl/msrv32_wb_arbiter.sv
// Writeback arbiter: merges the single-cycle port A and the FIFO-buffered long-latency
// port B into the register file write port, and keeps the RAW busy scoreboard.
module msrv32_wb_arbiter #(
  parameter int B_DEPTH      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        a_valid_in,
  output logic        a_ready_out,
  input  logic [4:0]  a_rd_addr_in,
  input  logic [31:0] a_data_in,
  input  logic        b_valid_in,
  output logic        b_ready_out,
  input  logic [4:0]  b_rd_addr_in,
  input  logic [31:0] b_data_in,
  input  logic        issue_valid_in,
  input  logic [4:0]  issue_rd_addr_in,
  input  logic [4:0]  rs_1_addr_in,
  input  logic [4:0]  rs_2_addr_in,
  output logic        hazard_out,
  output logic [31:0] busy_out,
  output logic        wr_en_out,
  output logic [4:0]  rd_addr_out,
  output logic [31:0] rd_out
);
  localparam int AW = $clog2(B_DEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t     fifo_mem [B_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [3:0]  starve_cnt, starve_nxt;
  logic [31:0] busy, busy_nxt;
  logic        empty, full, force_b, a_acc, b_push, b_pop;
  wb_ent_t     head, sel;
  logic        sel_vld;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = fifo_mem[rd_ptr[AW-1:0]];

  // Force only makes sense with something to drain; an empty FIFO never stalls A.
  assign force_b     = (starve_cnt == 4'(STARVE_LIMIT)) && !empty;
  assign a_ready_out = reset_in && !force_b;
  assign b_ready_out = reset_in && !full;
  assign a_acc       = a_valid_in && a_ready_out;
  assign b_push      = b_valid_in && b_ready_out;
  assign b_pop       = reset_in && !empty && (force_b || !a_valid_in);

  always_comb begin
    sel_vld = 1'b0;
    sel     = head;
    if (a_acc) begin
      sel_vld = 1'b1;
      sel     = '{addr: a_rd_addr_in, data: a_data_in};
    end else if (b_pop) begin
      sel_vld = 1'b1;
    end
  end

  always_comb begin
    starve_nxt = 4'd0;
    if (a_acc && !empty)
      starve_nxt = (starve_cnt == 4'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 4'd1;
  end

  // Issue is applied after the pop clear so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (b_pop)
      busy_nxt[head.addr] = 1'b0;
    if (issue_valid_in && (issue_rd_addr_in != 5'd0))
      busy_nxt[issue_rd_addr_in] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      starve_cnt  <= 4'd0;
      busy        <= 32'd0;
      wr_en_out   <= 1'b0;
      rd_addr_out <= 5'd0;
      rd_out      <= 32'd0;
    end else begin
      if (b_push) wr_ptr <= wr_ptr + 1'b1;
      if (b_pop)  rd_ptr <= rd_ptr + 1'b1;
      starve_cnt <= starve_nxt;
      busy       <= busy_nxt;
      wr_en_out  <= sel_vld && (sel.addr != 5'd0);
      if (sel_vld) begin
        rd_addr_out <= sel.addr;
        rd_out      <= sel.data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (b_push)
      fifo_mem[wr_ptr[AW-1:0]] <= '{addr: b_rd_addr_in, data: b_data_in};
  end

  assign busy_out   = busy;
  assign hazard_out = (busy[rs_1_addr_in] && (rs_1_addr_in != 5'd0)) ||
                      (busy[rs_2_addr_in] && (rs_2_addr_in != 5'd0));
endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Directed bench for msrv32_wb_arbiter: queue-based reference model compared every cycle,
// plus hand-computed literal checks at the interesting points of each scenario.
module tb_msrv32_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        a_valid_in, a_ready_out;
  logic [4:0]  a_rd_addr_in;
  logic [31:0] a_data_in;
  logic        b_valid_in, b_ready_out;
  logic [4:0]  b_rd_addr_in;
  logic [31:0] b_data_in;
  logic        issue_valid_in;
  logic [4:0]  issue_rd_addr_in, rs_1_addr_in, rs_2_addr_in;
  logic        hazard_out;
  logic [31:0] busy_out;
  logic        wr_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;

  int errors = 0;
  int checks = 0;

  msrv32_wb_arbiter #(.B_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .a_valid_in(a_valid_in), .a_ready_out(a_ready_out),
    .a_rd_addr_in(a_rd_addr_in), .a_data_in(a_data_in),
    .b_valid_in(b_valid_in), .b_ready_out(b_ready_out),
    .b_rd_addr_in(b_rd_addr_in), .b_data_in(b_data_in),
    .issue_valid_in(issue_valid_in), .issue_rd_addr_in(issue_rd_addr_in),
    .rs_1_addr_in(rs_1_addr_in), .rs_2_addr_in(rs_2_addr_in),
    .hazard_out(hazard_out), .busy_out(busy_out),
    .wr_en_out(wr_en_out), .rd_addr_out(rd_addr_out), .rd_out(rd_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending B results as a queue, starvation as a plain count.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t        q[$];
  ent_t        h;
  int          m_cnt = 0;
  int          n;
  bit          m_frc, m_acc, m_pop, started = 0;
  logic [31:0] m_busy = 0;
  logic        m_wr = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0;

  always @(posedge clk_in) begin
    started = 1;
    if (!reset_in) begin
      q.delete();
      m_cnt = 0; m_busy = 0; m_wr = 0; m_addr = 0; m_data = 0;
    end else begin
      n     = q.size();
      m_frc = (m_cnt == LIMIT) && (n > 0);
      m_acc = a_valid_in && !m_frc;
      m_pop = (n > 0) && !m_acc;
      if (m_acc) begin
        m_wr = (a_rd_addr_in != 0); m_addr = a_rd_addr_in; m_data = a_data_in;
      end else if (m_pop) begin
        h = q.pop_front();
        m_wr = (h.a != 0); m_addr = h.a; m_data = h.d;
        m_busy[h.a] = 1'b0;
      end else
        m_wr = 0;
      m_cnt = (m_acc && n > 0) ? ((m_cnt < LIMIT) ? m_cnt + 1 : LIMIT) : 0;
      if (issue_valid_in && issue_rd_addr_in != 0) m_busy[issue_rd_addr_in] = 1'b1;
      m_busy[0] = 1'b0;
      if (b_valid_in && n < DEPTH) q.push_back('{a: b_rd_addr_in, d: b_data_in});
    end
  end

  always @(negedge clk_in) begin
    if (started) begin
      chk("a_ready", a_ready_out, reset_in && !(m_cnt == LIMIT && q.size() > 0));
      chk("b_ready", b_ready_out, reset_in && (q.size() < DEPTH));
      chk("busy", busy_out, m_busy);
      chk("hazard", hazard_out, (m_busy[rs_1_addr_in] && rs_1_addr_in != 0) ||
                                (m_busy[rs_2_addr_in] && rs_2_addr_in != 0));
      chk("wr_en", wr_en_out, m_wr);
      if (m_wr) begin
        chk("rd_addr", rd_addr_out, m_addr);
        chk("rd_data", rd_out, m_data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  initial begin
    reset_in = 0;
    a_valid_in = 1; a_rd_addr_in = 5'd3; a_data_in = 32'h1;
    b_valid_in = 1; b_rd_addr_in = 5'd4; b_data_in = 32'h2;
    issue_valid_in = 1; issue_rd_addr_in = 5'd6;
    rs_1_addr_in = 5'd6; rs_2_addr_in = 5'd0;
    cyc(); cyc();
    chk("rst wr_en", wr_en_out, 0);
    chk("rst rd_addr", rd_addr_out, 0);
    chk("rst rd", rd_out, 0);
    chk("rst busy", busy_out, 0);
    chk("rst a_ready", a_ready_out, 0);
    chk("rst b_ready", b_ready_out, 0);
    chk("rst hazard", hazard_out, 0);

    reset_in = 1; a_valid_in = 0; b_valid_in = 0; issue_valid_in = 0;
    #1;
    chk("rel a_ready", a_ready_out, 1);
    chk("rel b_ready", b_ready_out, 1);

    // A only
    a_valid_in = 1; a_rd_addr_in = 5'd5; a_data_in = 32'h1234;
    cyc();
    chk("A wr_en", wr_en_out, 1);
    chk("A rd_addr", rd_addr_out, 5);
    chk("A rd", rd_out, 32'h1234);
    a_rd_addr_in = 5'd0; a_data_in = 32'hFFFF;
    cyc();
    chk("A x0 wr_en", wr_en_out, 0);
    a_valid_in = 0;
    cyc();

    // B buffering with scoreboard
    issue_valid_in = 1; issue_rd_addr_in = 5'd7; rs_1_addr_in = 5'd7;
    cyc();
    issue_valid_in = 0;
    #1;
    chk("busy7 set", busy_out[7], 1);
    chk("hazard7", hazard_out, 1);
    b_valid_in = 1; b_rd_addr_in = 5'd7; b_data_in = 32'hA5A5;
    cyc();
    b_valid_in = 0;
    chk("busy7 after push", busy_out[7], 1);
    chk("no bypass", wr_en_out, 0);
    cyc();
    chk("busy7 clr at pop", busy_out[7], 0);
    chk("hazard7 clr", hazard_out, 0);
    chk("B wr_en", wr_en_out, 1);
    chk("B rd_addr", rd_addr_out, 7);
    chk("B rd", rd_out, 32'hA5A5);
    cyc();
    chk("B single write", wr_en_out, 0);

    // Full, back-pressure and starvation
    a_valid_in = 1; a_rd_addr_in = 5'd3; a_data_in = 32'h33;
    b_valid_in = 1; b_rd_addr_in = 5'd1; b_data_in = 32'h111;
    cyc();
    b_rd_addr_in = 5'd2; b_data_in = 32'h222;
    cyc();
    chk("full b_ready", b_ready_out, 0);
    b_rd_addr_in = 5'd4; b_data_in = 32'h444;
    cyc(); cyc(); cyc();
    chk("starve A wr", rd_addr_out, 3);
    chk("force a_ready", a_ready_out, 0);
    cyc();
    chk("force1 wr_en", wr_en_out, 1);
    chk("force1 rd_addr", rd_addr_out, 1);
    chk("force1 rd", rd_out, 32'h111);
    chk("force1 a_ready back", a_ready_out, 1);
    cyc();
    b_valid_in = 0;
    cyc(); cyc(); cyc();
    chk("force2 a_ready", a_ready_out, 0);
    cyc();
    chk("force2 rd_addr", rd_addr_out, 2);
    chk("force2 rd", rd_out, 32'h222);
    a_valid_in = 0;
    cyc();
    chk("drain x4", rd_addr_out, 4);
    cyc();

    // Same-cycle set and clear of x9
    issue_valid_in = 1; issue_rd_addr_in = 5'd9;
    b_valid_in = 1; b_rd_addr_in = 5'd9; b_data_in = 32'h99;
    cyc();
    b_valid_in = 0;
    cyc();
    chk("busy9 set wins", busy_out[9], 1);
    chk("x9 wr_en", wr_en_out, 1);
    chk("x9 rd_addr", rd_addr_out, 9);
    issue_valid_in = 0;
    cyc();

    // Reset mid-operation drops pending entries and busy bits
    issue_valid_in = 1; issue_rd_addr_in = 5'd10;
    b_valid_in = 1; b_rd_addr_in = 5'd10; b_data_in = 32'hAA;
    cyc();
    issue_valid_in = 0; b_valid_in = 0; reset_in = 0;
    cyc();
    chk("midrst busy", busy_out, 0);
    reset_in = 1;
    cyc();
    chk("midrst no write", wr_en_out, 0);

    // Mixed traffic pattern
    for (int i = 0; i < 24; i++) begin
      a_valid_in       = (i % 3) != 0;
      a_rd_addr_in     = 5'(i);
      a_data_in        = 32'(i * 32'h101);
      b_valid_in       = (i % 2) == 1;
      b_rd_addr_in     = 5'(i * 7);
      b_data_in        = ~32'(i);
      issue_valid_in   = (i % 5) == 0;
      issue_rd_addr_in = 5'(i + 3);
      rs_1_addr_in     = 5'(i + 3);
      rs_2_addr_in     = 5'(i * 7);
      cyc();
    end
    a_valid_in = 0; b_valid_in = 0; issue_valid_in = 0;
    repeat (6) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
